if_fetch_queue: RTL
===================

// Module: if_fetch_queue
// PURPOSE
//  Instruction-fetch front end for the pipelined MIPS core: owns the fetch PC, issues word reads to a
//  synchronous instruction memory (1-cycle read latency), buffers returned words with their PC in a
//  small prefetch queue, and hands {pc, ins} to the decode stage over a valid/ready handshake.
//  Branch/jump resolution downstream redirects it via redirect_valid/redirect_pc.
// PARAMETERS
//  DEPTH     4             queue entries; power of two, >= 2
//  RESET_PC  32'h0000_3000 first fetch address after reset
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   asynchronous, active-low reset (0 = reset)
//  imem_req       out  1   fetch request
//  imem_addr      out  32  byte address of requested word, [1:0] always 2'b00
//  imem_gnt       in   1   memory accepts request this cycle
//  imem_rdata     in   32  instruction word, valid the cycle after an accepted request
//  id_valid       out  1   queue head available to decode
//  id_ready       in   1   decode consumes head this cycle
//  id_pc          out  32  PC of head entry
//  id_ins         out  32  instruction of head entry
//  redirect_valid in   1   flush and restart fetch
//  redirect_pc    in   32  new fetch address; bits [1:0] ignored (forced 0)
// BEHAVIOUR
//  - Reset (rst=0, async): fetch_pc=RESET_PC, queue empty, inflight=0, state=BOOT; imem_req=0,
//    imem_addr=RESET_PC, id_valid=0, id_pc=0, id_ins=0.
//  - FSM: BOOT -> FETCH after one clock with rst=1 (no request in BOOT).
//    FETCH: imem_req=1 iff count+inflight < DEPTH and !redirect_valid; else WAIT_CREDIT.
//    WAIT_CREDIT -> FETCH when credit frees. Any state except BOOT -> FETCH on redirect.
//  - Issue: accepted when imem_req&&imem_gnt; fetch_pc+=4, inflight=1 next cycle. Without gnt, imem_req
//    and imem_addr hold stable until gnt or redirect.
//  - Response: in the cycle inflight=1, imem_rdata is pushed with its PC unless killed. Credit
//    accounting guarantees a push never finds the queue full.
//  - Output: id_valid = !empty && !redirect_valid; pop when id_valid&&id_ready. Push+pop same cycle:
//    count unchanged. Empty: id_pc/id_ins hold last value. Pointers wrap mod DEPTH.
//  - Redirect in cycle t: queue cleared and fetch_pc=redirect_pc at end of t; the response arriving
//    in t is dropped; no issue in t; first request for redirect_pc raised in t+1.
//    Redirect overrides a simultaneous pop, push and request.
//  - Latency: accepted request at t -> id_valid with that entry at t+2 (queue previously empty).
//  - fetch_pc wraps 32'hFFFF_FFFC -> 0 silently.
// CONFIGURATION
//  IF_PERF_EN defined: adds outputs perf_fetch_cnt[31:0] (entries popped to decode) and
//  perf_stall_cnt[31:0] (cycles id_valid=1 && id_ready=0); both reset to 0, saturate at all-ones.
//  Not defined: ports and counters absent; fetch behaviour identical.
// STRUCTURE
//  - Shared header if_defs.v: `IF_INS_W (32), `IF_PC_W (32), state encodings IF_S_BOOT/FETCH/
//    WAIT_CREDIT, default RESET_PC value.
//  - Sub-module if_queue: sync FIFO of {pc,ins}, DEPTH entries, push/pop/clear, count output,
//    same async active-low reset; top holds FSM, fetch_pc, inflight/kill logic, perf counters.
// TESTING
//  1 rst rises, gnt=1, id_ready=1 -> first imem_req 2nd cycle, addr 0x3000,0x3004,...;
//    id_valid with id_pc=0x3000 two cycles after first accept, then one entry per cycle.
//  2 id_ready=0 from reset -> exactly 4 requests accepted then imem_req=0; head stays pc 0x3000;
//    id_ready=1 -> 0x3000..0x300C in order, fetch resumes at 0x3010.
//  3 queue holds 2, one request in flight, redirect_pc=0x3101 -> id_valid=0 that cycle, in-flight
//    word dropped, next imem_addr=0x3100, next id_pc=0x3100.
//  4 imem_gnt=0 for 3 cycles with req pending at 0x3008 -> req/addr stable all 3 cycles, one accept.
//  5 rst pulled low mid-cycle while queue full -> id_valid, imem_req drop without clock edge;
//    after release fetch restarts at 0x3000.
//  6 IF_PERF_EN: 5 stall cycles then 3 pops -> perf_stall_cnt=5, perf_fetch_cnt=3.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: data widths, default reset PC, fetch FSM state encoding and
// the {pc, ins} entry type carried by the prefetch queue.
package if_fetch_queue_pkg;

    localparam int IF_INS_W = 32;
    localparam int IF_PC_W  = 32;

    localparam logic [IF_PC_W-1:0] IF_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IF_S_BOOT        = 2'd0,
        IF_S_FETCH       = 2'd1,
        IF_S_WAIT_CREDIT = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [IF_PC_W-1:0]  pc;
        logic [IF_INS_W-1:0] ins;
    } if_entry_t;

endpackage

// File: rtl/if_fetch_queue_queue.sv
// Synchronous FIFO of {pc, ins} entries with push/pop/clear and occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller keeps pushes within capacity, pops are ignored when empty.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   push_i / push_dat_i   write one entry at the tail
//   pop_i                 retire the head entry
//   clear_i               drop all entries (wins over push and pop)
//   head_dat_o            entry at the head (stale when empty)
//   empty_o, count_o      occupancy status
module if_fetch_queue_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  if_entry_t                    push_dat_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    output if_entry_t                    head_dat_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !clear_i;
    assign do_pop  = pop_i && !clear_i && !empty_o;

    // Storage needs no reset: nothing is read out until it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns fetch PC, issues word reads, buffers {pc, ins} for decode.
// Latency: request accepted in cycle t -> entry presented to decode in t+2 (empty queue).
// Backpressure: requests stop while queued + in-flight words would exceed DEPTH; decode stalls via id_ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   imem_req/addr/gnt/rdata       instruction memory port, 1-cycle read latency
//   id_valid/ready/pc/ins         decode handshake, head of the prefetch queue
//   redirect_valid/redirect_pc    flush queue and restart fetch at redirect_pc (word aligned)
//   perf_fetch_cnt/stall_cnt      only with IF_PERF_EN: pops to decode / stalled-valid cycles
// Optional feature macro: IF_PERF_EN.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int                 DEPTH    = 4,
    parameter logic [IF_PC_W-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [IF_PC_W-1:0]  imem_addr,
    input  logic                imem_gnt,
    input  logic [IF_INS_W-1:0] imem_rdata,
    output logic                id_valid,
    input  logic                id_ready,
    output logic [IF_PC_W-1:0]  id_pc,
    output logic [IF_INS_W-1:0] id_ins,
`ifdef IF_PERF_EN
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt,
`endif
    input  logic                redirect_valid,
    input  logic [IF_PC_W-1:0]  redirect_pc
);

    localparam int CW = $clog2(DEPTH+1);

    if_state_e           state_q;
    logic [IF_PC_W-1:0]  fetch_pc_q;
    logic [IF_PC_W-1:0]  fetch_pc_d;
    logic                inflight_q;
    logic [IF_PC_W-1:0]  inflight_pc_q;
    if_entry_t           hold_q;

    logic                accept;
    logic                push;
    logic                pop;
    logic                credit_ok;
    logic [CW:0]         occupancy;
    logic                q_empty;
    logic [CW-1:0]       q_count;
    if_entry_t           q_head;
    if_entry_t           push_dat;
    if_entry_t           head;
    logic                unused_redirect_lo;

    // Low address bits of a redirect are forced to zero.
    assign unused_redirect_lo = ^redirect_pc[1:0];

    // Every in-flight word already owns a queue slot, so a response never meets a full queue.
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
    assign credit_ok = occupancy < (CW+1)'(DEPTH);

    assign imem_req  = (state_q != IF_S_BOOT) && credit_ok && !redirect_valid;
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_gnt;

    // A redirect kills the response landing in the same cycle; later responses cannot
    // belong to the old stream because no request is accepted while redirecting.
    assign push         = inflight_q && !redirect_valid;
    assign push_dat.pc  = inflight_pc_q;
    assign push_dat.ins = imem_rdata;

    assign id_valid = !q_empty && !redirect_valid;
    assign pop      = id_valid && id_ready;

    // While empty the decode-facing fields keep showing the last head seen.
    assign head   = q_empty ? hold_q : q_head;
    assign id_pc  = head.pc;
    assign id_ins = head.ins;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[IF_PC_W-1:2], 2'b00};
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + IF_PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IF_S_BOOT;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            hold_q        <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= accept;
            if (accept) begin
                inflight_pc_q <= fetch_pc_q;
            end
            if (!q_empty) begin
                hold_q <= q_head;
            end
            case (state_q)
                IF_S_BOOT: begin
                    state_q <= IF_S_FETCH;
                end
                IF_S_FETCH: begin
                    if (!redirect_valid && !credit_ok) begin
                        state_q <= IF_S_WAIT_CREDIT;
                    end
                end
                IF_S_WAIT_CREDIT: begin
                    if (redirect_valid || credit_ok) begin
                        state_q <= IF_S_FETCH;
                    end
                end
                default: begin
                    state_q <= IF_S_BOOT;
                end
            endcase
        end
    end

    if_fetch_queue_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .clear_i    (redirect_valid),
        .head_dat_o (q_head),
        .empty_o    (q_empty),
        .count_o    (q_count)
    );

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pop && (perf_fetch_q != '1)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (id_valid && !id_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
